// File: rtl/spi_upcount_pkg.sv
// rtl/spi_upcount_pkg.sv - shared constants and types for the up-counter SPI slave
//
// Purpose: frame geometry, frame tag value and the slave FSM state encoding.
// Ports: none (package).

package spi_upcount_pkg;

  localparam int FRAME_BITS = 16;
  localparam int COUNTER_W  = 14;

  // Upper frame bits must carry this tag for the payload to be accepted.
  localparam logic [1:0] FRAME_TAG = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_SS = 2'd2
  } spi_slave_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchronizer with registered edge pulses
//
// Purpose: brings an asynchronous level into the clk domain and flags its edges.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   din          - asynchronous input level
//   dout         - synchronized level
//   rise, fall   - one-cycle pulses on synchronized rising / falling edges

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  assign dout = sync[STAGES-1];

  // Edge pulses are registered, so they trail the synchronized level by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_upcount_slave.sv
// rtl/spi_upcount_slave.sv - SPI mode-0 slave receiving 16-bit up-counter frames
//
// Purpose: reassembles MSB-first frames, accepts tag-00 frames as the counter
// value and flags aborted or mistagged frames.
// Optional feature macro: SPI_UPCOUNT_SLAVE_ECHO_EN (echo last frame on miso).
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   sclk, mosi, ss - SPI lines from the master (asynchronous, ss active-low)
//   miso           - echo of the last accepted frame (0 without echo build)
//   o_counter      - last accepted counter value
//   o_valid        - one-cycle pulse when o_counter updates
//   o_frame_err    - one-cycle pulse on aborted or mistagged frame

module spi_upcount_slave #(
  parameter int FRAME_BITS  = spi_upcount_pkg::FRAME_BITS,
  parameter int COUNTER_W   = spi_upcount_pkg::COUNTER_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss,
  output logic                 miso,
  output logic [COUNTER_W-1:0] o_counter,
  output logic                 o_valid,
  output logic                 o_frame_err
);

  import spi_upcount_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS) + 1;
  localparam int TAG_W = FRAME_BITS - COUNTER_W;

  spi_slave_state_e state_q, state_d;

  logic                   sclk_lvl, sclk_rise, sclk_fall;
  logic                   ss_lvl, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [FRAME_BITS-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   frame_done;
  logic                   tag_ok;

  logic                   start;
  logic                   shift_en;
  logic                   valid_d;
  logic                   err_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .dout  (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ss),
    .dout  (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // Synchronized sclk level is not needed; its fall pulse only in the echo build.
  logic unused_sclk;
  assign unused_sclk = ^{sclk_lvl, sclk_fall};

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync[i] <= mosi_sync[i-1];
      end
    end
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign frame_done = (bit_cnt == CNT_W'(FRAME_BITS));
  assign tag_ok     = (shift_reg[FRAME_BITS-1:COUNTER_W] == TAG_W'(FRAME_TAG));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ss_fall) state_d = SHIFT;
      end
      SHIFT: begin
        // A completed frame whose ss rise lands in the same cycle must not
        // park in WAIT_SS.
        if (frame_done)   state_d = ss_rise ? IDLE : WAIT_SS;
        else if (ss_rise) state_d = IDLE;
      end
      WAIT_SS: begin
        if (ss_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        start = ss_fall;
      end
      SHIFT: begin
        if (frame_done) begin
          valid_d = tag_ok;
          err_d   = ~tag_ok;
        end else if (ss_rise) begin
          err_d = 1'b1;
        end else begin
          // ss rise outranks a coincident sclk edge (handled above).
          shift_en = sclk_rise;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      o_counter   <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= valid_d;
      o_frame_err <= err_d;
      if (start) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      if (valid_d) begin
        o_counter <= shift_reg[COUNTER_W-1:0];
      end
    end
  end

`ifdef SPI_UPCOUNT_SLAVE_ECHO_EN
  logic [FRAME_BITS-1:0] echo_reg;

  // Loaded at frame start so the MSB is on miso before the first sclk rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_reg <= '0;
    end else if (start) begin
      echo_reg <= {TAG_W'(FRAME_TAG), o_counter};
    end else if (state_q == SHIFT && sclk_fall) begin
      echo_reg <= {echo_reg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign miso = (state_q == SHIFT) ? echo_reg[FRAME_BITS-1] : 1'b0;
`else
  assign miso = 1'b0;
`endif

endmodule
